// File: rtl/decade_pkg.sv
// Shared definitions for the decade counter family: FSM state encoding,
// the largest legal BCD digit and a digit-range check.
package decade_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic digit_valid(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Multi-digit packed BCD down-counter with parallel load.
// The counter holds at zero instead of wrapping.
module bcd_down_counter
  import decade_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  dec,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero
);

  logic [4*DIGITS-1:0] decremented;
  logic                borrow;

  // Ripple the borrow upward: a zero digit wraps to 9 and passes the borrow on.
  always_comb begin
    decremented = count;
    borrow      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          decremented[4*i +: 4] = BCD_MAX;
        end else begin
          decremented[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow                = 1'b0;
        end
      end
    end
  end

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= din;
    end else if (dec && !zero) begin
      count <= decremented;
    end
  end

endmodule

// File: rtl/decade_pulse_gen.sv
// Emits N single-cycle pulses (N given as packed BCD) separated by GAP low
// cycles, then a one-cycle done strobe; malformed BCD requests raise err.
module decade_pulse_gen
  import decade_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int GAP    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int               GAP_W      = $clog2(GAP) + 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);

  state_t              state;
  state_t              next_state;
  logic [GAP_W-1:0]    gap_cnt;
  logic [4*DIGITS-1:0] count;
  logic                zero;
  logic                all_valid;
  logic                req_zero;
  logic                accept;
  logic                load;
  logic                dec;
  logic                last_pulse;

  always_comb begin
    all_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(bcd_in[4*i +: 4])) begin
        all_valid = 1'b0;
      end
    end
  end

  assign req_zero   = (bcd_in == '0);
  assign accept     = (state == IDLE) && start;
  assign load       = accept && all_valid && !req_zero;
  assign dec        = (state == HIGH);
  // The pulse being emitted now is the last one when the count is about to hit zero.
  assign last_pulse = (count == (4*DIGITS)'(1)) || zero;

  bcd_down_counter #(
    .DIGITS (DIGITS)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (bcd_in),
    .dec   (dec),
    .count (count),
    .zero  (zero)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && all_valid) begin
          next_state = req_zero ? DONE : HIGH;
        end
      end
      HIGH:    next_state = last_pulse ? DONE : LOW;
      LOW: begin
        if (gap_cnt == '0) begin
          next_state = HIGH;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      out     <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= next_state;
      if (state == HIGH) begin
        gap_cnt <= GAP_RELOAD;
      end else if (state == LOW && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      out  <= (next_state == HIGH);
      done <= (next_state == DONE);
      err  <= accept && !all_valid;
    end
  end

  assign ready = (state == IDLE);
  assign busy  = !ready;

endmodule

// File: tb/tb_decade_pulse_gen.sv
// Randomized and directed bench for decade_pulse_gen; expected outputs come
// from a timeline model built on the documented pulse/done cycle formulas.
module tb_decade_pulse_gen;

  localparam int DIGITS = 2;
  localparam int GAP    = 2;
  localparam int PERIOD = GAP + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic                ready;
  logic                out;
  logic                busy;
  logic                done;
  logic                err;

  always #5 clk = ~clk;

  decade_pulse_gen #(
    .DIGITS (DIGITS),
    .GAP    (GAP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcd_in),
    .ready  (ready),
    .out    (out),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int pulse_total  = 0;

  // Model: one accepted burst described by its accept cycle, length and done cycle.
  bit m_active     = 1'b0;
  bit m_ready      = 1'b1;
  int m_acc        = 0;
  int m_n          = 0;
  int m_done_cycle = 0;
  int m_err_cycle  = -1;

  function automatic bit req_valid(input logic [4*DIGITS-1:0] b);
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int req_value(input logic [4*DIGITS-1:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d",
               tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [4*DIGITS-1:0] b,
                               input logic r);
    bit e_out;
    bit e_done;
    bit e_err;
    int k;
    start  = s;
    bcd_in = b;
    rst    = r;
    if (r) begin
      m_active    = 1'b0;
      m_err_cycle = -1;
    end else if (s && m_ready) begin
      if (!req_valid(b)) begin
        m_err_cycle = cyc + 1;
      end else begin
        m_active     = 1'b1;
        m_acc        = cyc;
        m_n          = req_value(b);
        m_done_cycle = (m_n == 0) ? cyc + 1 : cyc + 1 + (m_n - 1) * PERIOD + 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (m_active && cyc > m_done_cycle) m_active = 1'b0;
    k       = cyc - m_acc - 1;
    e_out   = m_active && (k >= 0) && (k % PERIOD == 0) && (k / PERIOD < m_n);
    e_done  = m_active && (cyc == m_done_cycle);
    e_err   = (cyc == m_err_cycle);
    m_ready = !m_active;
    if (out === 1'b1) pulse_total++;
    checkOutput("out",   32'(out),   32'(e_out));
    checkOutput("done",  32'(done),  32'(e_done));
    checkOutput("err",   32'(err),   32'(e_err));
    checkOutput("ready", 32'(ready), 32'(m_ready));
    checkOutput("busy",  32'(busy),  32'(!m_ready));
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [4*DIGITS-1:0] b;
    logic                s;
    logic                r;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;

    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] three pulses");
    applyStimulus(1'b1, 8'h03, 1'b0);
    runIdle(12);

    $display("[TB] zero-length request");
    applyStimulus(1'b1, 8'h00, 1'b0);
    runIdle(4);

    $display("[TB] invalid digit followed by immediate valid request");
    applyStimulus(1'b1, 8'h1A, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    runIdle(6);

    $display("[TB] ninety-nine pulses");
    pulse_total = 0;
    applyStimulus(1'b1, 8'h99, 1'b0);
    runIdle(300);
    checkOutput("pulses_99", 32'(pulse_total), 32'd99);

    $display("[TB] start during burst is ignored");
    pulse_total = 0;
    applyStimulus(1'b1, 8'h03, 1'b0);
    runIdle(1);
    applyStimulus(1'b1, 8'h05, 1'b0);
    runIdle(12);
    checkOutput("pulses_3", 32'(pulse_total), 32'd3);

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 8'h05, 1'b0);
    runIdle(3);
    applyStimulus(1'b0, '0, 1'b1);
    runIdle(3);
    applyStimulus(1'b1, 8'h02, 1'b0);
    runIdle(10);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      b[7:4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                           : 4'($urandom_range(0, 2));
      b[3:0] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                           : 4'($urandom_range(0, 9));
      applyStimulus(s, b, r);
    end
    runIdle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/decade_pulse_gen.md
# decade_pulse_gen

Transmit-side companion to `decade_counter`. It accepts a multi-digit BCD count over a start/ready handshake and drives exactly that many single-cycle pulses on `out`. Adjacent pulses are separated by a programmable low gap, so a downstream pulse counter sees one clean edge per pulse. The block sits on the stimulus/source side of the counter chain and signals completion with a one-cycle `done`.

## Interface
- `DIGITS`, 2: number of BCD digits in `bcd_in`; 1..4.
- `GAP`, 1: low cycles between consecutive pulses; must be >= 1.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only on a cycle where `ready`=1.
- `bcd_in`  in  4*DIGITS  pulse count, packed BCD, digit 0 in bits [3:0]; sampled on accept.
- `ready`  out  1  idle and able to accept `start`.
- `out`  out  1  pulse output, registered.
- `busy`  out  1  burst in progress; equals !`ready`.
- `done`  out  1  one-cycle strobe when a burst completes, including N=0.
- `err`  out  1  one-cycle strobe when a request had a digit > 9.

## Operation
- FSM states are IDLE, HIGH, LOW, DONE.
- IDLE:
  - `ready`=1.
  - On `start` with any digit > 9: `err`=1 next cycle, nothing is loaded, and the FSM stays in IDLE.
  - On `start` with all digits valid and value N=0: go to DONE.
  - Otherwise: load the BCD down-counter with `bcd_in` and go to HIGH.
- HIGH:
  - `out`=1 for exactly one cycle, and the counter decrements by 1.
  - If the post-decrement count is 0, go to DONE; else load the gap counter with GAP-1 and go to LOW.
- LOW: `out`=0. Stay GAP cycles in total, then go to HIGH.
- DONE: `done`=1 for one cycle, then go to IDLE.
- BCD decrement:
  - Digit 0 decrements; each digit wraps 0->9 and borrows from the next digit.
  - Zero is detected as all digits == 0.
  - The counter never decrements below 0.
- `start` while `busy` is ignored and not queued. `bcd_in` changes during a burst have no effect.
- `err` and `done` are never asserted in the same cycle.
- `out`, `done` and `err` are registered outputs with no combinational path from inputs.

## Timing
- Reset values: `out`=0, `done`=0, `err`=0, `ready`=1, `busy`=0; FSM in IDLE; counters cleared.
- Reset mid-burst: outputs take their reset values on the cycle after `rst` is sampled high. No `done` is issued for the aborted burst.
- `rst` has priority over `start` in the same cycle.
- Let the accept edge be cycle 0.
  - Pulse i (i = 0..N-1) is high in cycle 1 + i*(GAP+1).
  - `done` is high in cycle 1 + (N-1)*(GAP+1) + 1, i.e. the cycle immediately after the last pulse.
  - `ready` returns in the cycle after `done`.
- N=0: `done` in cycle 1, `ready` in cycle 2; `out` never rises.
- Invalid digit: `err` in cycle 1; `ready` stays 1 throughout, so a new request is accepted in cycle 1.
- Maximum burst is 10^DIGITS - 1 pulses.
- Pulse period is GAP+1 cycles. Duty is 1/(GAP+1).

## Structure
- Shared package `decade_pkg` holds:
  - the FSM state encoding (IDLE/HIGH/LOW/DONE);
  - constant `BCD_MAX`=9;
  - a digit-valid function.
- `decade_counter` and its benches also use `decade_pkg`.
- One sub-module, `bcd_down_counter`:
  - parameter `DIGITS`;
  - ports `clk`, `rst`, `load`, `din`, `dec`, `count`, `zero`;
  - holds the borrow-chain decrement.
- The top level holds the FSM, the gap counter (width clog2(GAP)+1), the validation logic and the output registers.

## Test plan
- N=3 (`bcd_in`=8'h03), GAP=1, start at cycle 0 -> `out` high in cycles 1, 3, 5 only; `done` in cycle 6; `ready` in cycle 7.
- N=0 (`bcd_in`=8'h00) -> `out` stays 0; `done` in cycle 1; `ready` in cycle 2; `err`=0.
- `bcd_in`=8'h1A -> `err` in cycle 1, no pulses, `done`=0, `ready` stays 1; a valid 8'h01 start in cycle 1 then yields a pulse in cycle 2.
- N=99 (`bcd_in`=8'h99), GAP=2 -> exactly 99 pulses with period 3, the last in cycle 295; `done` in cycle 296. This checks the 90->89 and 10->09 borrows.
- `start` with 8'h05 in cycle 2 during an N=3 burst -> ignored; exactly 3 pulses total.
- `rst` high in cycle 4 of an N=5 burst -> `out`=0 and `ready`=1 from cycle 5; no `done`; a new start afterwards runs normally.
